// File: rtl/sega_saturn_abus_pkg.sv
// Shared types and constants for the Saturn A-bus initiator.
package sega_saturn_abus_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StSetup,
    StStrobe,
    StHold,
    StResp
  } abus_state_e;

  // Chip-select index meaning "no bus cycle, respond at once".
  localparam logic [1:0] CS_NONE = 2'd3;

  // Phase counter covers ADDR/SETUP/STROBE/HOLD lengths; timeout counter covers wait extension.
  localparam int unsigned CNT_W = 8;
  localparam int unsigned TO_W  = 16;

  // Chip-select index to one-hot-low select lines.
  function automatic logic [2:0] cs_to_cs_n(input logic [1:0] cs);
    logic [2:0] cs_n;
    case (cs)
      2'd0:    cs_n = 3'b110;
      2'd1:    cs_n = 3'b101;
      2'd2:    cs_n = 3'b011;
      default: cs_n = 3'b111;
    endcase
    return cs_n;
  endfunction

endpackage

// File: rtl/sega_saturn_abus_sync.sv
// N-flop synchronizer / delay line with a configurable reset value.
module sega_saturn_abus_sync #(
  parameter int unsigned      Stages   = 2,
  parameter int unsigned      Width    = 1,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Stages-1:0][Width-1:0] stage_q;

  // Shift the input through the flop chain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stage_q <= {Stages{ResetVal}};
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < Stages; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[Stages-1];

endmodule

// File: rtl/sega_saturn_abus_master.sv
// Saturn A-bus initiator: one Avalon-style command becomes one timed A-bus cycle.
// Optional build macro SEGA_SATURN_ABUS_MASTER_WAIT_SYNC_EN: abus_wait and the read-back
// data pass through a 2-flop pipe and the minimum strobe grows by 2 clocks.
module sega_saturn_abus_master
  import sega_saturn_abus_pkg::*;
#(
  parameter int unsigned ADDR_CYC    = 2,
  parameter int unsigned SETUP_CYC   = 1,
  parameter int unsigned STROBE_CYC  = 4,
  parameter int unsigned HOLD_CYC    = 1,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_cs,
  input  logic [25:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic [1:0]  cmd_be,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  output logic [9:0]  abus_address,
  output logic [15:0] abus_ad_o,
  output logic        abus_ad_oe,
  input  logic [15:0] abus_ad_i,
  output logic        abus_as_n,
  output logic [2:0]  abus_cs_n,
  output logic        abus_rd_n,
  output logic [1:0]  abus_wr_n,
  input  logic        abus_wait,
  input  logic        abus_irq_n,
  output logic        irq
);

  localparam int unsigned ACyc    = (ADDR_CYC < 1) ? 1 : ADDR_CYC;
  localparam int unsigned StbBase = (STROBE_CYC < 1) ? 1 : STROBE_CYC;

  logic        wait_s;
  logic [15:0] rd_src;

`ifdef SEGA_SATURN_ABUS_MASTER_WAIT_SYNC_EN
  // Wait arrives two clocks late, so the strobe minimum absorbs that latency.
  localparam int unsigned StbMin = StbBase + 2;

  sega_saturn_abus_sync #(.Stages(2), .Width(1), .ResetVal(1'b0)) u_wait_sync (
    .clk_i  (clk_clk),
    .rst_ni (reset_reset_n),
    .d_i    (abus_wait),
    .q_o    (wait_s)
  );

  // Read data delayed by the same depth so it lines up with the synchronized wait.
  sega_saturn_abus_sync #(.Stages(2), .Width(16), .ResetVal(16'h0000)) u_data_pipe (
    .clk_i  (clk_clk),
    .rst_ni (reset_reset_n),
    .d_i    (abus_ad_i),
    .q_o    (rd_src)
  );
`else
  localparam int unsigned StbMin = StbBase;

  assign wait_s = abus_wait;
  assign rd_src = abus_ad_i;
`endif

  logic irq_n_s;

  sega_saturn_abus_sync #(.Stages(2), .Width(1), .ResetVal(1'b1)) u_irq_sync (
    .clk_i  (clk_clk),
    .rst_ni (reset_reset_n),
    .d_i    (abus_irq_n),
    .q_o    (irq_n_s)
  );

  assign irq = ~irq_n_s;

  abus_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [TO_W-1:0]  ext_q;
  logic             init_q;
  logic             wr_q, to_q;
  logic [1:0]       cs_q, be_q;
  logic [25:0]      addr_q;
  logic [15:0]      wdata_q, rdata_q;
  logic             accept, min_met, strobe_done, strobe_abort;

  assign accept  = cmd_valid && cmd_ready;
  assign min_met = (cnt_q >= CNT_W'(StbMin - 1));

  // State register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= StIdle;
    else                state_q <= state_d;
  end

  // Next-state decode; phase lengths come from the clock counter.
  always_comb begin
    state_d      = state_q;
    strobe_done  = 1'b0;
    strobe_abort = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) state_d = (cmd_cs == CS_NONE) ? StResp : StAddr;
      end
      StAddr: begin
        if (cnt_q == CNT_W'(ACyc - 1)) state_d = (SETUP_CYC > 0) ? StSetup : StStrobe;
      end
      StSetup: begin
        if (cnt_q == CNT_W'(SETUP_CYC - 1)) state_d = StStrobe;
      end
      StStrobe: begin
        if (min_met) begin
          if (!wait_s) begin
            strobe_done = 1'b1;
          end else if (ext_q >= TO_W'(TIMEOUT_CYC)) begin
            strobe_done  = 1'b1;
            strobe_abort = 1'b1;
          end
        end
        if (strobe_done) state_d = (HOLD_CYC > 0) ? StHold : StResp;
      end
      StHold: begin
        if (cnt_q == CNT_W'(HOLD_CYC - 1)) state_d = StResp;
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Phase/extension counters, command latch and response capture.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      cnt_q   <= '0;
      ext_q   <= '0;
      init_q  <= 1'b0;
      wr_q    <= 1'b0;
      cs_q    <= CS_NONE;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      init_q <= 1'b1;
      if (state_d != state_q)  cnt_q <= '0;
      else if (cnt_q != '1)    cnt_q <= cnt_q + CNT_W'(1);
      if (state_q != StStrobe)  ext_q <= '0;
      else if (min_met && wait_s) ext_q <= ext_q + TO_W'(1);
      if (accept) begin
        wr_q    <= cmd_write;
        cs_q    <= cmd_cs;
        be_q    <= cmd_be;
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        if (cmd_cs == CS_NONE) begin
          rdata_q <= '0;
          to_q    <= 1'b0;
        end
      end
      if (strobe_done) begin
        to_q    <= strobe_abort;
        rdata_q <= strobe_abort ? 16'hFFFF : (wr_q ? 16'h0000 : rd_src);
      end
    end
  end

  // Bus and handshake outputs decoded from the current phase.
  always_comb begin
    abus_as_n    = 1'b1;
    abus_cs_n    = 3'b111;
    abus_rd_n    = 1'b1;
    abus_wr_n    = 2'b11;
    abus_ad_oe   = 1'b0;
    abus_ad_o    = '0;
    abus_address = addr_q[25:16];
    cmd_ready    = (state_q == StIdle) && init_q;
    rsp_valid    = (state_q == StResp);
    rsp_timeout  = (state_q == StResp) && to_q;
    rsp_rdata    = rdata_q;
    case (state_q)
      StAddr: begin
        abus_as_n  = 1'b0;
        abus_ad_oe = 1'b1;
        abus_ad_o  = addr_q[15:0];
      end
      StSetup, StStrobe, StHold: begin
        abus_cs_n  = cs_to_cs_n(cs_q);
        abus_ad_oe = wr_q;
        abus_ad_o  = wr_q ? wdata_q : 16'h0000;
        if (state_q == StStrobe) begin
          abus_rd_n = wr_q;
          abus_wr_n = wr_q ? ~be_q : 2'b11;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sega_saturn_abus_master.sv
// Self-checking bench for sega_saturn_abus_master (default build, TIMEOUT_CYC=16).
module tb_sega_saturn_abus_master;

  localparam int A  = 2;
  localparam int S  = 1;
  localparam int ST = 4;
  localparam int H  = 1;
  localparam int TO = 16;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [1:0]  cmd_cs, cmd_be;
  logic [25:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [15:0] rsp_rdata;
  logic [9:0]  abus_address;
  logic [15:0] abus_ad_o, abus_ad_i;
  logic        abus_ad_oe, abus_as_n, abus_rd_n, abus_wait, abus_irq_n, irq;
  logic [2:0]  abus_cs_n;
  logic [1:0]  abus_wr_n;

  int n_tests = 0;
  int n_fail  = 0;

  sega_saturn_abus_master #(
    .ADDR_CYC(A), .SETUP_CYC(S), .STROBE_CYC(ST), .HOLD_CYC(H), .TIMEOUT_CYC(TO)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_cs        (cmd_cs),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .cmd_be        (cmd_be),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_timeout   (rsp_timeout),
    .abus_address  (abus_address),
    .abus_ad_o     (abus_ad_o),
    .abus_ad_oe    (abus_ad_oe),
    .abus_ad_i     (abus_ad_i),
    .abus_as_n     (abus_as_n),
    .abus_cs_n     (abus_cs_n),
    .abus_rd_n     (abus_rd_n),
    .abus_wr_n     (abus_wr_n),
    .abus_wait     (abus_wait),
    .abus_irq_n    (abus_irq_n),
    .irq           (irq)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before 500us");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  // {as_n, cs_n, rd_n, wr_n, ad_oe}; released bus reads 8'hFE.
  function automatic logic [7:0] bus_word();
    return {abus_as_n, abus_cs_n, abus_rd_n, abus_wr_n, abus_ad_oe};
  endfunction

  function automatic logic [2:0] exp_cs_n(input logic [1:0] cs);
    logic [2:0] v;
    v = 3'b111;
    if (cs != 2'd3) v[cs] = 1'b0;
    return v;
  endfunction

  // One command. wm[c] is the target's wait level during cycle c after the accepting edge.
  task automatic run_cmd(input logic w, input logic [1:0] cs, input logic [25:0] a,
                         input logic [15:0] wd, input logic [1:0] be,
                         input logic [63:0] wm, input logic [15:0] rdv);
    int len, exp_lat, rsp_c, as_cnt, cs_cnt, rd_cnt, wr_cnt, rdy_hi, bad;
    logic abort;
    logic [15:0] exp_rd, got_rd;
    logic got_to;
    logic [7:0] rel;
    // Reference: strobe clock k exits once k >= ST with wait low, aborts after TO extra clocks.
    abort = 1'b0;
    len   = 0;
    if (cs != 2'd3) begin
      for (int k = 1; k < 40; k++) begin
        if (k >= ST && !wm[A+S+k]) begin len = k; break; end
        if (k >= ST + TO) begin len = k; abort = 1'b1; break; end
      end
      exp_lat = A + S + len + H + 1;
    end else begin
      exp_lat = 1;
    end
    exp_rd = abort ? 16'hFFFF : ((cs == 2'd3 || w) ? 16'h0000 : rdv);

    for (int i = 0; i < 50 && !cmd_ready; i++) tick();
    check_eq("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = w; cmd_cs = cs; cmd_addr = a; cmd_wdata = wd; cmd_be = be;
    abus_ad_i = rdv; abus_wait = wm[0];
    tick();
    cmd_valid = 1'b0;
    rsp_c = -1; as_cnt = 0; cs_cnt = 0; rd_cnt = 0; wr_cnt = 0; rdy_hi = 0; bad = 0;
    got_rd = '0; got_to = 1'b0; rel = '0;
    for (int c = 1; c < 100; c++) begin
      abus_wait = wm[c];
      if (cmd_ready) rdy_hi++;
      if (!abus_as_n) begin
        as_cnt++;
        if (abus_address !== a[25:16] || abus_ad_o !== a[15:0] || !abus_ad_oe) bad++;
      end
      if (abus_cs_n != 3'b111) begin
        cs_cnt++;
        if (abus_cs_n !== exp_cs_n(cs)) bad++;
        if (abus_ad_oe !== w || (w && abus_ad_o !== wd)) bad++;
      end
      if (!abus_rd_n) rd_cnt++;
      if (abus_wr_n != 2'b11) begin
        wr_cnt++;
        if (abus_wr_n !== ~be) bad++;
      end
      if (rsp_valid) begin
        rsp_c = c; got_rd = rsp_rdata; got_to = rsp_timeout; rel = bus_word();
        break;
      end
      tick();
    end
    check_eq("rsp_latency", rsp_c, exp_lat);
    check_eq("rsp_timeout", got_to, abort);
    if (!w || cs == 2'd3) check_eq("rsp_rdata", got_rd, exp_rd);
    check_eq("as_n_low_clocks", as_cnt, (cs == 2'd3) ? 0 : A);
    check_eq("cs_n_low_clocks", cs_cnt, (cs == 2'd3) ? 0 : S + len + H);
    check_eq("rd_n_low_clocks", rd_cnt, (!w && cs != 2'd3) ? len : 0);
    check_eq("wr_n_low_clocks", wr_cnt, (w && cs != 2'd3 && be != 2'b00) ? len : 0);
    check_eq("bus_values_in_cycle", bad, 0);
    check_eq("ready_low_while_busy", rdy_hi, 0);
    check_eq("bus_released_at_rsp", rel, 8'hFE);
    tick();
    check_eq("rsp_single_pulse", rsp_valid, 0);
  endtask

  initial begin
    int accepts, rsps, rdy_cnt, bad;
    logic acc;
    logic [63:0] wm;

    reset_reset_n = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_cs = 2'd0; cmd_addr = '0; cmd_wdata = '0;
    cmd_be = 2'b00; abus_ad_i = '0; abus_wait = 1'b0; abus_irq_n = 1'b1;
    repeat (3) tick();
    check_eq("reset_bus", bus_word(), 8'hFE);
    check_eq("reset_ad_o", abus_ad_o, 0);
    check_eq("reset_address", abus_address, 0);
    check_eq("reset_ready", cmd_ready, 0);
    check_eq("reset_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
    check_eq("reset_irq", irq, 0);
    reset_reset_n = 1'b1;
    check_eq("ready_first_cycle", cmd_ready, 0);
    tick();
    check_eq("ready_after_first", cmd_ready, 1);

    // Interrupt synchronizer: visible after two edges.
    abus_irq_n = 1'b0;
    tick();
    check_eq("irq_one_edge", irq, 0);
    tick();
    check_eq("irq_two_edges", irq, 1);
    abus_irq_n = 1'b1;
    tick(); tick();
    check_eq("irq_cleared", irq, 0);

    // Directed cases.
    run_cmd(1'b1, 2'd0, 26'h0123456, 16'hBEEF, 2'b11, 64'd0, 16'h0000);
    run_cmd(1'b0, 2'd1, 26'h2ABCDEF, 16'h0000, 2'b11, 64'h380, 16'hA55A);
    run_cmd(1'b0, 2'd2, 26'h1000002, 16'h0000, 2'b11, '1, 16'h1357);
    run_cmd(1'b1, 2'd1, 26'h0000010, 16'h00C3, 2'b01, 64'd0, 16'h0000);
    run_cmd(1'b1, 2'd2, 26'h0000020, 16'h00C4, 2'b00, 64'd0, 16'h0000);
    run_cmd(1'b0, 2'd3, 26'h3FFFFFF, 16'h0000, 2'b11, 64'd0, 16'h7777);

    // Randomized commands with short wait extensions and noise before the minimum.
    for (int t = 0; t < 24; t++) begin
      int ext;
      ext = $urandom_range(0, 5);
      wm  = {$urandom, $urandom};
      wm  = (wm & ((64'd1 << (A + S + ST)) - 1)) | (((64'd1 << ext) - 1) << (A + S + ST));
      run_cmd(1'($urandom), 2'($urandom), 26'($urandom), 16'($urandom), 2'($urandom),
              wm, 16'($urandom));
    end

    // Back-to-back reads with cmd_valid held.
    cmd_write = 1'b0; cmd_cs = 2'd1; cmd_addr = 26'h0456789; cmd_be = 2'b11;
    abus_wait = 1'b0; abus_ad_i = 16'h1234; cmd_valid = 1'b1;
    accepts = 0; rsps = 0; rdy_cnt = 0; bad = 0;
    for (int i = 0; i < 120; i++) begin
      acc = cmd_valid && cmd_ready;
      if (acc) rdy_cnt++;
      if (cmd_ready && (!abus_as_n || abus_cs_n != 3'b111)) bad++;
      if (rsp_valid) begin
        rsps++;
        if (rsp_rdata !== 16'h1234) bad++;
      end
      tick();
      if (acc) begin
        accepts++;
        if (accepts == 8) cmd_valid = 1'b0;
      end
    end
    check_eq("b2b_rsp_count", rsps, 8);
    check_eq("b2b_ready_cycles", rdy_cnt, 8);
    check_eq("b2b_bad", bad, 0);
    run_cmd(1'b0, 2'd3, 26'h0000001, 16'h0000, 2'b11, 64'd0, 16'h0000);

    // Reset in the middle of a stalled strobe.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_cs = 2'd0; cmd_addr = 26'h0ABCDEF;
    abus_wait = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    check_eq("pre_reset_rd_low", abus_rd_n, 0);
    reset_reset_n = 1'b0;
    #1;
    check_eq("async_reset_bus", bus_word(), 8'hFE);
    check_eq("async_reset_rsp", rsp_valid, 0);
    abus_wait = 1'b0;
    tick();
    check_eq("reset_hold_rsp", rsp_valid, 0);
    reset_reset_n = 1'b1;
    check_eq("rerelease_ready_first", cmd_ready, 0);
    tick();
    check_eq("rerelease_ready", cmd_ready, 1);
    run_cmd(1'b1, 2'd2, 26'h0155AA5, 16'h5AA5, 2'b10, 64'd0, 16'h0000);
    run_cmd(1'b0, 2'd0, 26'h0300000, 16'h0000, 2'b11, 64'h080, 16'hC0DE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
